// File: rtl/seg_scan_if.sv
// seg_scan_if: signal bundle between the scan controller and its environment
// (numeric datapath, shared BCD-to-7-segment decoder, display pins).
//   load       one-cycle request to capture bcd_in
//   bcd_in     packed BCD, nibble k is digit k (digit 0 least significant)
//   blank_lz   1 = blank leading zeros
//   bcd_out    nibble presented to the external decoder
//   seg_in     decoder result for bcd_out (combinational return)
//   seg_out    registered segment drive, active-high
//   an         registered one-hot digit enable, active-high
//   frame_done one-cycle pulse after each full scan
//   err        sticky invalid-BCD flag
// master: environment side; slave: controller side.
interface seg_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  blank_lz;
  logic [3:0]            bcd_out;
  logic [6:0]            seg_in;
  logic [6:0]            seg_out;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;
  logic                  err;

  modport master (
    output load, bcd_in, blank_lz, seg_in,
    input  bcd_out, seg_out, an, frame_done, err
  );

  modport slave (
    input  load, bcd_in, blank_lz, seg_in,
    output bcd_out, seg_out, an, frame_done, err
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller sharing one external
// combinational BCD-to-7-segment decoder across DIGITS common-anode digits.
// Holds a tear-free display buffer (new data only takes effect at a frame
// boundary), blanks all digit enables for the first BLANK_CYC cycles of each
// slot, optionally suppresses leading zeros and flags nibbles above 9.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous reset, active-high
//   bus  seg_scan_if.slave (load, bcd_in, blank_lz, seg_in in;
//        bcd_out, seg_out, an, frame_done, err out)
// Parameters:
//   DIGITS       digit positions (2..8)
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//   BLANK_CYC    leading blanked cycles of each slot (< REFRESH_DIV)
module seg_scan_ctrl #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned BLANK_CYC   = 16
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = $clog2(DIGITS);

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_P    = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  // Scan position
  logic [PW-1:0]              presc;
  logic [IW-1:0]              idx;

  // Display buffers: active is what is being scanned, pending holds the
  // most recent load until the next frame boundary.
  logic [DIGITS-1:0][3:0]     active;
  logic [DIGITS-1:0][3:0]     pending;
  logic                       pend_v;

  // Registered outputs
  logic [6:0]                 seg_q;
  logic [DIGITS-1:0]          an_q;
  logic                       frame_done_q;
  logic                       err_q;

  // Combinational helpers
  logic                       slot_end;
  logic                       boundary;
  logic [3:0]                 cur_nib;
  logic                       invalid;
  logic [DIGITS-1:0]          lz_mask;
  logic                       zero_run;
  logic                       blanked;
  logic                       in_blank;
  logic [6:0]                 seg_d;
  logic [DIGITS-1:0]          an_d;

  // --------------------------------------------------------------------
  // Scan counters
  // --------------------------------------------------------------------
  always_comb begin
    slot_end = (presc == PRESC_LAST);
    boundary = slot_end && (idx == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (slot_end) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // --------------------------------------------------------------------
  // Double buffering
  // A load on the boundary cycle bypasses pending so it is never lost and
  // never delayed by a whole extra frame.
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= '0;
      pending <= '0;
      pend_v  <= 1'b0;
    end else if (boundary) begin
      if (bus.load) begin
        active <= bus.bcd_in;
        pend_v <= 1'b0;
      end else if (pend_v) begin
        active <= pending;
        pend_v <= 1'b0;
      end
    end else if (bus.load) begin
      pending <= bus.bcd_in;
      pend_v  <= 1'b1;
    end
  end

  // --------------------------------------------------------------------
  // Decoder feed and digit qualification
  // --------------------------------------------------------------------
  always_comb begin
    cur_nib = active[idx];
    invalid = (cur_nib > 4'd9);
  end

  assign bus.bcd_out = cur_nib;

  // Walk from the most significant digit down; a digit is blanked while every
  // nibble from the top down to it is zero. Digit 0 always stays visible.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      zero_run = zero_run && (active[IW'(DIGITS - 1 - j)] == 4'd0);
      if (bus.blank_lz && zero_run && (j != DIGITS - 1))
        lz_mask[IW'(DIGITS - 1 - j)] = 1'b1;
    end
  end

  always_comb begin
    blanked  = lz_mask[idx];
    in_blank = (presc < BLANK_P);
    seg_d    = (blanked || invalid) ? '0 : bus.seg_in;
    an_d     = '0;
    if (!in_blank)
      an_d[idx] = 1'b1;
  end

  // --------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q        <= '0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= boundary;
      err_q        <= err_q | invalid;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1.
// Reference model tracks elapsed cycles since reset and derives slot, phase
// and frame position arithmetically; display data and flags follow the
// double-buffer rules at whole-value level.
module tb_seg_scan_ctrl;

  localparam int unsigned D     = 4;
  localparam int unsigned RD    = 4;
  localparam int unsigned BC    = 1;
  localparam int unsigned FRAME = D * RD;

  logic clk;
  logic rst;

  seg_scan_if #(.DIGITS(D)) bus ();

  seg_scan_ctrl #(
    .DIGITS      (D),
    .REFRESH_DIV (RD),
    .BLANK_CYC   (BC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External decoder model; codes above 9 return a nonzero pattern so the
  // controller's invalid-code suppression is observable.
  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'd0: dec7 = 7'h3F; 4'd1: dec7 = 7'h06; 4'd2: dec7 = 7'h5B;
      4'd3: dec7 = 7'h4F; 4'd4: dec7 = 7'h66; 4'd5: dec7 = 7'h6D;
      4'd6: dec7 = 7'h7D; 4'd7: dec7 = 7'h07; 4'd8: dec7 = 7'h7F;
      4'd9: dec7 = 7'h6F;
      default: dec7 = 7'h79;
    endcase
  endfunction

  assign bus.seg_in = dec7(bus.bcd_out);

  int total = 0;
  int bad   = 0;

  // Reference model state
  int unsigned  m_t;
  logic [15:0]  m_active;
  logic [15:0]  m_pend;
  logic         m_pv;
  logic         m_err;
  logic         m_valid = 1'b0;
  logic         cur_blz = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, m_t);
    end
  endtask

  // One clock: drive inputs, predict, clock, update model, compare.
  task automatic tick(input logic ld, input logic [15:0] val, input logic blz, input logic r);
    int unsigned digit;
    logic [3:0]  nib;
    logic [15:0] upper;
    logic        blanked, inv;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_fd, e_err;

    bus.load     = ld;
    bus.bcd_in   = val;
    bus.blank_lz = blz;
    rst          = r;

    digit   = (m_t / RD) % D;
    upper   = m_active >> (4 * digit);
    nib     = upper[3:0];
    blanked = blz && (digit != 0) && (upper == 16'h0);
    inv     = (nib > 4'd9);
    e_seg   = (blanked || inv) ? 7'h00 : dec7(nib);
    e_an    = ((m_t % RD) < BC) ? 4'b0000 : 4'(1 << digit);
    e_fd    = ((m_t % FRAME) == FRAME - 1);
    e_err   = m_err | inv;

    #1;
    if (m_valid && !r) chk("bcd_out", 32'(bus.bcd_out), 32'(nib));

    @(posedge clk);
    #1;

    if (r) begin
      m_t = 0; m_active = '0; m_pend = '0; m_pv = 1'b0; m_err = 1'b0;
      m_valid = 1'b1;
      e_seg = '0; e_an = '0; e_fd = 1'b0; e_err = 1'b0;
    end else begin
      if ((m_t % FRAME) == FRAME - 1) begin
        if (ld) begin
          m_active = val; m_pv = 1'b0;
        end else if (m_pv) begin
          m_active = m_pend; m_pv = 1'b0;
        end
      end else if (ld) begin
        m_pend = val; m_pv = 1'b1;
      end
      m_err = e_err;
      m_t++;
    end

    chk("seg_out",    32'(bus.seg_out),    32'(e_seg));
    chk("an",         32'(bus.an),         32'(e_an));
    chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
    chk("err",        32'(bus.err),        32'(e_err));
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick(1'b0, 16'h0000, cur_blz, 1'b0);
  endtask

  task automatic run_to(input int unsigned phase);
    for (int unsigned i = 0; i < FRAME; i++) begin
      if ((m_t % FRAME) == phase) break;
      tick(1'b0, 16'h0000, cur_blz, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] v;
    rst = 1'b1;
    bus.load = 1'b0;
    bus.bcd_in = '0;
    bus.blank_lz = 1'b0;
    m_t = 0; m_active = '0; m_pend = '0; m_pv = 1'b0; m_err = 1'b0;

    // Reset, then free-run with no load: zeros in every slot
    tick(1'b0, 16'h0000, 1'b0, 1'b1);
    tick(1'b0, 16'h0000, 1'b0, 1'b1);
    idle(40);

    // Two loads in one frame: last wins, applied at the boundary
    run_to(5);
    tick(1'b1, 16'h1234, cur_blz, 1'b0);
    run_to(9);
    tick(1'b1, 16'h5678, cur_blz, 1'b0);
    idle(24);

    // Leading-zero blanking
    cur_blz = 1'b1;
    tick(1'b1, 16'h0042, cur_blz, 1'b0);
    idle(36);
    tick(1'b1, 16'h0000, cur_blz, 1'b0);
    idle(36);
    cur_blz = 1'b0;
    idle(20);

    // Invalid nibble sets sticky err
    tick(1'b1, 16'h9A01, cur_blz, 1'b0);
    idle(36);
    tick(1'b1, 16'h0000, cur_blz, 1'b0);
    idle(36);
    tick(1'b0, 16'h0000, cur_blz, 1'b1);
    idle(20);

    // Load on the exact boundary cycle overrides an earlier pending load
    run_to(4);
    tick(1'b1, 16'h5555, cur_blz, 1'b0);
    run_to(FRAME - 1);
    tick(1'b1, 16'h4321, cur_blz, 1'b0);
    chk("pend_v", 32'(dut.pend_v), 32'd0);
    idle(20);

    // Reset during slot 2 with a load pending
    run_to(3);
    tick(1'b1, 16'h7777, cur_blz, 1'b0);
    run_to(9);
    tick(1'b0, 16'h0000, cur_blz, 1'b1);
    chk("idx_after_rst", 32'(dut.idx), 32'd0);
    idle(40);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 4; k++)
        v[4*k +: 4] = ($urandom_range(0, 19) == 0) ? 4'hB : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 2) == 0) v[15:8] = 8'h00;
      if ($urandom_range(0, 31) == 0) cur_blz = ~cur_blz;
      tick(($urandom_range(0, 7) == 0), v, cur_blz, ($urandom_range(0, 149) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
